// File: rtl/square_wave_analyzer_if.sv
// Bundle of the analyzer's sample input, slicer thresholds and measurement results.
// The master drives samples and thresholds; the slave (the analyzer) returns the results.
interface square_wave_analyzer_if;
    logic [7:0]  dacLevel;
    logic [7:0]  thresholdHigh;
    logic [7:0]  thresholdLow;
    logic [31:0] periodCycles;
    logic [31:0] highCycles;
    logic [31:0] frequencyWord;
    logic        measValid;
    logic        noSignal;
    logic        overrun;

    modport master (
        output dacLevel, thresholdHigh, thresholdLow,
        input  periodCycles, highCycles, frequencyWord, measValid, noSignal, overrun
    );

    modport slave (
        input  dacLevel, thresholdHigh, thresholdLow,
        output periodCycles, highCycles, frequencyWord, measValid, noSignal, overrun
    );
endinterface

// File: rtl/square_wave_analyzer.sv
// Hysteresis slicer plus period/high-time counter for a sampled square wave, with a
// bit-serial restoring divider that turns the period into a DDS frequency word.
module square_wave_analyzer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd16777216
) (
    input  logic                  clk,
    input  logic                  rst,
    square_wave_analyzer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

    localparam logic [5:0]  DIV_STEPS = 6'd33;
    localparam logic [32:0] DIVIDEND  = 33'h1_0000_0000;
    localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

    state_t      state_q, state_d;
    logic        slicer_q, slicer_d;
    logic [31:0] per_cnt_q, per_cnt_d;
    logic [31:0] high_cnt_q, high_cnt_d;
    logic [31:0] lat_per_q, lat_per_d;
    logic [31:0] lat_high_q, lat_high_d;
    logic [31:0] rem_q, rem_d;
    logic [32:0] quo_q, quo_d;
    logic [5:0]  div_cnt_q, div_cnt_d;
    logic [31:0] per_out_q, per_out_d;
    logic [31:0] high_out_q, high_out_d;
    logic [31:0] freq_out_q, freq_out_d;
    logic        meas_valid_q, meas_valid_d;
    logic        no_signal_q, no_signal_d;
    logic        overrun_q, overrun_d;

    logic        rise;
    logic [32:0] trial;
    logic        trial_ge;
    logic [31:0] trial_diff;

    always_comb begin
        state_d      = state_q;
        slicer_d     = slicer_q;
        per_cnt_d    = per_cnt_q;
        high_cnt_d   = high_cnt_q;
        lat_per_d    = lat_per_q;
        lat_high_d   = lat_high_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        div_cnt_d    = div_cnt_q;
        per_out_d    = per_out_q;
        high_out_d   = high_out_q;
        freq_out_d   = freq_out_q;
        meas_valid_d = 1'b0;
        no_signal_d  = no_signal_q;
        overrun_d    = overrun_q;

        // Between the thresholds the slicer keeps its previous decision.
        if (bus.dacLevel >= bus.thresholdHigh) begin
            slicer_d = 1'b1;
        end else if (bus.dacLevel <= bus.thresholdLow) begin
            slicer_d = 1'b0;
        end
        rise = slicer_d & ~slicer_q;

        // Counters restart on every rising edge, so per_cnt_q at an edge equals t1-t0.
        if (rise) begin
            per_cnt_d  = 32'd1;
            high_cnt_d = 32'd1;
        end else begin
            if (per_cnt_q != ALL_ONES) begin
                per_cnt_d = per_cnt_q + 32'd1;
            end
            if (slicer_d && (high_cnt_q != ALL_ONES)) begin
                high_cnt_d = high_cnt_q + 32'd1;
            end
        end

        // One restoring-division step: shift in the next dividend bit and try to subtract.
        trial      = {rem_q, quo_q[32]};
        trial_ge   = (trial >= {1'b0, lat_per_q});
        trial_diff = trial[31:0] - lat_per_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    lat_per_d  = per_cnt_q;
                    lat_high_d = high_cnt_q;
                    rem_d      = 32'd0;
                    quo_d      = DIVIDEND;
                    div_cnt_d  = 6'd0;
                    state_d    = DIVIDE;
                end else if (per_cnt_q >= TIMEOUT_CYCLES) begin
                    per_out_d   = 32'd0;
                    high_out_d  = 32'd0;
                    freq_out_d  = 32'd0;
                    no_signal_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            DIVIDE: begin
                // An edge here drops the period it closes; counting already restarted above.
                if (rise) begin
                    overrun_d = 1'b1;
                end
                if (div_cnt_q == DIV_STEPS) begin
                    per_out_d    = lat_per_q;
                    high_out_d   = lat_high_q;
                    freq_out_d   = quo_q[31:0];
                    meas_valid_d = 1'b1;
                    no_signal_d  = 1'b0;
                    state_d      = MEASURE;
                end else begin
                    rem_d     = trial_ge ? trial_diff : trial[31:0];
                    quo_d     = {quo_q[31:0], trial_ge};
                    div_cnt_d = div_cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            slicer_q     <= 1'b0;
            per_cnt_q    <= 32'd0;
            high_cnt_q   <= 32'd0;
            lat_per_q    <= 32'd0;
            lat_high_q   <= 32'd0;
            rem_q        <= 32'd0;
            quo_q        <= 33'd0;
            div_cnt_q    <= 6'd0;
            per_out_q    <= 32'd0;
            high_out_q   <= 32'd0;
            freq_out_q   <= 32'd0;
            meas_valid_q <= 1'b0;
            no_signal_q  <= 1'b1;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slicer_q     <= slicer_d;
            per_cnt_q    <= per_cnt_d;
            high_cnt_q   <= high_cnt_d;
            lat_per_q    <= lat_per_d;
            lat_high_q   <= lat_high_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            div_cnt_q    <= div_cnt_d;
            per_out_q    <= per_out_d;
            high_out_q   <= high_out_d;
            freq_out_q   <= freq_out_d;
            meas_valid_q <= meas_valid_d;
            no_signal_q  <= no_signal_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.periodCycles  = per_out_q;
    assign bus.highCycles    = high_out_q;
    assign bus.frequencyWord = freq_out_q;
    assign bus.measValid     = meas_valid_q;
    assign bus.noSignal      = no_signal_q;
    assign bus.overrun       = overrun_q;

endmodule
